// File: rtl/mac_operand_feeder_pkg.sv
// Shared MAC definitions: default operand geometry and the frame-tracking state encoding.
package mac_operand_feeder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    FIRST = 1'b0,
    MID   = 1'b1
  } frame_state_e;

endpackage

// File: rtl/mac_operand_feeder_mem.sv
// Operand-pair storage: one synchronous write port, one asynchronous read port.
module pair_fifo_mem
  import mac_operand_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [2*WIDTH:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [2*WIDTH:0]         rd_data
);

  // Contents are deliberately left out of reset; level tracking makes stale words invisible.
  logic [2*WIDTH:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_operand_feeder.sv
// Operand-pair FIFO in front of a MAC, flagging the first term of each dot-product frame.
module mac_operand_feeder
  import mac_operand_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_a,
  input  logic [WIDTH-1:0]         wr_b,
  input  logic                     wr_last,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_a,
  output logic [WIDTH-1:0]         rd_b,
  output logic                     rd_last,
  output logic                     acc_clr,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  frame_state_e     state_reg;
  logic [2*WIDTH:0] head_word;
  logic             do_wr;
  logic             do_rd;

  // Handshake flags come from registered level only, so there is no comb path input-to-ready.
  assign wr_ready = (level_reg != LW'(DEPTH));
  assign rd_valid = (level_reg != '0);
  assign do_wr    = wr_valid && wr_ready;
  assign do_rd    = rd_valid && rd_ready;

  pair_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (do_wr && !rst),
    .wr_addr (wr_ptr_reg),
    .wr_data ({wr_last, wr_b, wr_a}),
    .rd_addr (rd_ptr_reg),
    .rd_data (head_word)
  );

  assign rd_a    = head_word[WIDTH-1:0];
  assign rd_b    = head_word[2*WIDTH-1:WIDTH];
  assign rd_last = head_word[2*WIDTH];
  assign acc_clr = rd_valid && (state_reg == FIRST);
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      state_reg  <= FIRST;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      // Frame tracking advances only on consumed pairs.
      if (do_rd) begin
        case (state_reg)
          FIRST:   state_reg <= rd_last ? FIRST : MID;
          MID:     state_reg <= rd_last ? FIRST : MID;
          default: state_reg <= FIRST;
        endcase
      end
    end
  end

endmodule
